// File: rtl/mips_isa_pkg.sv
// Shared MIPS-31 encoding constants, symbolic op index and loader FSM states.
// Imported by the field packer and the IMEM loader.
package mips_isa_pkg;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0a;
    localparam logic [5:0] OPC_SLTIU = 6'h0b;
    localparam logic [5:0] OPC_ANDI  = 6'h0c;
    localparam logic [5:0] OPC_ORI   = 6'h0d;
    localparam logic [5:0] OPC_XORI  = 6'h0e;
    localparam logic [5:0] OPC_LUI   = 6'h0f;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    // Index order: R-type 0..16, I-type 17..28, J-type 29..30.
    typedef enum logic [4:0] {
        OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR, OP_NOR,
        OP_SLT, OP_SLTU, OP_SRA, OP_SRL, OP_SLL, OP_SRAV, OP_SRLV, OP_SLLV,
        OP_JR,
        OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LW, OP_SW, OP_BEQ,
        OP_BNE, OP_SLTI, OP_SLTIU, OP_LUI,
        OP_J, OP_JAL,
        OP_ILLEGAL
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FULL
    } state_t;

endpackage

// File: rtl/instr_field_packer.sv
// Combinational packer: symbolic op plus raw fields -> 32-bit MIPS word.
// Fields an instruction does not use are forced to zero.
module instr_field_packer
    import mips_isa_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] addr,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (op_t'(op))
            OP_ADD:   word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
            OP_ADDU:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_ADDU};
            OP_SUB:   word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
            OP_SUBU:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_SUBU};
            OP_AND:   word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_AND};
            OP_OR:    word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_OR};
            OP_XOR:   word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_XOR};
            OP_NOR:   word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_NOR};
            OP_SLT:   word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
            OP_SLTU:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_SLTU};
            // Immediate shifts: the only users of shamt, and they have no rs.
            OP_SRA:   word = {OPC_RTYPE, 5'd0, rt, rd, shamt, FN_SRA};
            OP_SRL:   word = {OPC_RTYPE, 5'd0, rt, rd, shamt, FN_SRL};
            OP_SLL:   word = {OPC_RTYPE, 5'd0, rt, rd, shamt, FN_SLL};
            OP_SRAV:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_SRAV};
            OP_SRLV:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_SRLV};
            OP_SLLV:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_SLLV};
            OP_JR:    word = {OPC_RTYPE, rs, 15'd0, FN_JR};
            OP_ADDI:  word = {OPC_ADDI, rs, rt, imm};
            OP_ADDIU: word = {OPC_ADDIU, rs, rt, imm};
            OP_ANDI:  word = {OPC_ANDI, rs, rt, imm};
            OP_ORI:   word = {OPC_ORI, rs, rt, imm};
            OP_XORI:  word = {OPC_XORI, rs, rt, imm};
            OP_LW:    word = {OPC_LW, rs, rt, imm};
            OP_SW:    word = {OPC_SW, rs, rt, imm};
            OP_BEQ:   word = {OPC_BEQ, rs, rt, imm};
            OP_BNE:   word = {OPC_BNE, rs, rt, imm};
            OP_SLTI:  word = {OPC_SLTI, rs, rt, imm};
            OP_SLTIU: word = {OPC_SLTIU, rs, rt, imm};
            OP_LUI:   word = {OPC_LUI, 5'd0, rt, imm};
            OP_J:     word = {OPC_J, addr};
            OP_JAL:   word = {OPC_JAL, addr};
            default:  legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Boot/test loader: accepts symbolic instructions over valid/ready, packs them
// and streams the words into consecutive IMEM locations starting at BASE_ADDR.
module instr_encoder_loader
    import mips_isa_pkg::*;
#(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter int          CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             finish,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_op,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_shamt,
    input  logic [15:0]      in_imm,
    input  logic [25:0]      in_addr,
    output logic             imem_we,
    output logic [31:0]      imem_addr,
    output logic [31:0]      imem_wdata,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             err_illegal,
    output state_t           state
);

    // Handshake: a beat transfers on a rising clk edge where in_valid and
    // in_ready are both high; in_ready never depends on in_valid.

    state_t      state_next;
    logic        accept;
    logic        done_next;
    logic [31:0] word;
    logic        legal;

    instr_field_packer u_packer (
        .op    (in_op),
        .rs    (in_rs),
        .rt    (in_rt),
        .rd    (in_rd),
        .shamt (in_shamt),
        .imm   (in_imm),
        .addr  (in_addr),
        .word  (word),
        .legal (legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        in_ready   = (state == ST_LOAD) && (count < CNT_W'(DEPTH));
        accept     = in_valid && in_ready;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // finish takes priority over filling up; the beat still lands.
                if (finish) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end else if (accept && legal && (count == CNT_W'(DEPTH - 1))) begin
                    state_next = ST_FULL;
                end
            end
            ST_FULL: begin
                if (finish) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count       <= '0;
            err_illegal <= 1'b0;
            imem_we     <= 1'b0;
            imem_addr   <= BASE_ADDR;
            imem_wdata  <= '0;
            done        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            done    <= done_next;
            if ((state == ST_IDLE) && start) begin
                count       <= '0;
                err_illegal <= 1'b0;
            end
            if (accept) begin
                if (legal) begin
                    imem_we    <= 1'b1;
                    imem_addr  <= BASE_ADDR + (32'(count) << 2);
                    imem_wdata <= word;
                    count      <= count + CNT_W'(1);
                end else begin
                    err_illegal <= 1'b1;
                end
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: a default-depth and a DEPTH=4 instance share
// one stimulus stream and are compared every cycle against a behavioural model.
module tb_instr_encoder_loader;
    import mips_isa_pkg::*;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        finish = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  in_op = '0;
    logic [4:0]  in_rs = '0;
    logic [4:0]  in_rt = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_shamt = '0;
    logic [15:0] in_imm = '0;
    logic [25:0] in_addr = '0;

    logic        ready_a, we_a, busy_a, done_a, err_a;
    logic [31:0] addr_a, wdata_a;
    logic [10:0] count_a;
    state_t      st_a;
    logic        ready_b, we_b, busy_b, done_b, err_b;
    logic [31:0] addr_b, wdata_b;
    logic [2:0]  count_b;
    state_t      st_b;

    int n_pass = 0;
    int n_total = 0;

    // Behavioural model, index 0 = default instance, 1 = DEPTH=4 instance.
    int          m_depth[2] = '{1024, 4};
    bit          m_sess[2];
    int          m_cnt[2];
    bit          m_err[2];
    bit          m_we[2];
    bit          m_done[2];
    logic [31:0] m_addr[2];
    logic [31:0] m_wdata[2];
    logic [63:0] exp_q[$];

    int fn_tab[17]  = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 3, 2, 0, 7, 6, 4, 8};
    int opc_tab[14] = '{8, 9, 12, 13, 14, 35, 43, 4, 5, 10, 11, 15, 2, 3};

    instr_encoder_loader u_a (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(ready_a), .in_op(in_op), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
        .in_addr(in_addr), .imem_we(we_a), .imem_addr(addr_a),
        .imem_wdata(wdata_a), .count(count_a), .busy(busy_a), .done(done_a),
        .err_illegal(err_a), .state(st_a)
    );

    instr_encoder_loader #(.DEPTH(4)) u_b (
        .clk(clk), .rst(rst), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(ready_b), .in_op(in_op), .in_rs(in_rs),
        .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
        .in_addr(in_addr), .imem_we(we_b), .imem_addr(addr_b),
        .imem_wdata(wdata_b), .count(count_b), .busy(busy_b), .done(done_b),
        .err_illegal(err_b), .state(st_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [31:0] ref_encode(int op, int rs, int rt, int rd, int sh,
                                               int imm, int addr);
        logic [31:0] w;
        if (op <= 16) begin
            if (op < 10 || op > 12) sh = 0;
            if (op >= 10 && op <= 12) rs = 0;
            if (op == 16) begin rt = 0; rd = 0; end
            w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6)
                | 32'(fn_tab[op]);
        end else if (op <= 28) begin
            if (op == 28) rs = 0;
            w = (32'(opc_tab[op-17]) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
        end else begin
            w = (32'(opc_tab[op-17]) << 26) | 32'(addr);
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_sess[i] = 0; m_cnt[i] = 0; m_err[i] = 0; m_we[i] = 0; m_done[i] = 0;
            m_addr[i] = BASE; m_wdata[i] = '0;
        end
        exp_q.delete();
    endtask

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            m_we[i] = 0;
            m_done[i] = 0;
            if (!m_sess[i]) begin
                if (start) begin m_sess[i] = 1; m_cnt[i] = 0; m_err[i] = 0; end
            end else begin
                if (in_valid && m_cnt[i] < m_depth[i]) begin
                    if (in_op == 5'd31) begin
                        m_err[i] = 1;
                    end else begin
                        m_we[i] = 1;
                        m_addr[i] = BASE + 32'(4 * m_cnt[i]);
                        m_wdata[i] = ref_encode(int'(in_op), int'(in_rs), int'(in_rt),
                            int'(in_rd), int'(in_shamt), int'(in_imm), int'(in_addr));
                        m_cnt[i]++;
                        if (i == 0) exp_q.push_back({m_addr[i], m_wdata[i]});
                    end
                end
                if (finish) begin m_sess[i] = 0; m_done[i] = 1; end
            end
        end
    endtask

    task automatic compare_inst(input string nm, input int i, input logic rdy, input logic we,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input int cnt, input logic busy, input logic done,
                                input logic err, input state_t st);
        state_t exp_st;
        exp_st = !m_sess[i] ? ST_IDLE : (m_cnt[i] == m_depth[i] ? ST_FULL : ST_LOAD);
        check({nm, ".state"}, 32'(st), 32'(exp_st));
        check({nm, ".ready"}, 32'(rdy), 32'(m_sess[i] && m_cnt[i] < m_depth[i]));
        check({nm, ".we"}, 32'(we), 32'(m_we[i]));
        check({nm, ".addr"}, addr, m_addr[i]);
        check({nm, ".wdata"}, wdata, m_wdata[i]);
        check({nm, ".count"}, 32'(cnt), 32'(m_cnt[i]));
        check({nm, ".busy"}, 32'(busy), 32'(m_sess[i]));
        check({nm, ".done"}, 32'(done), 32'(m_done[i]));
        check({nm, ".err"}, 32'(err), 32'(m_err[i]));
    endtask

    task automatic compare_all();
        logic [63:0] e;
        compare_inst("a", 0, ready_a, we_a, addr_a, wdata_a, int'(count_a), busy_a, done_a,
                     err_a, st_a);
        compare_inst("b", 1, ready_b, we_b, addr_b, wdata_b, int'(count_b), busy_b, done_b,
                     err_b, st_b);
        if (we_a) begin
            if (exp_q.size() == 0) begin
                check("sb.extra_write", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                check("sb.addr", addr_a, e[63:32]);
                check("sb.wdata", wdata_a, e[31:0]);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic beat(input int op, input int rs, input int rt, input int rd, input int sh,
                        input int imm, input int addr, input bit fin);
        in_valid = 1'b1;
        in_op = 5'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
        in_shamt = 5'(sh); in_imm = 16'(imm); in_addr = 26'(addr);
        finish = fin;
        step();
        in_valid = 1'b0;
        finish = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        check("reset.addr", addr_a, 32'h0040_0000);
        rst = 1'b0;

        start = 1'b1; step(); start = 1'b0;

        beat(1, 2, 3, 4, 7, 0, 0, 0);
        check("addu.we", 32'(we_a), 32'(1));
        check("addu.addr", addr_a, 32'h0040_0000);
        check("addu.wdata", wdata_a, 32'h0043_2021);
        beat(12, 9, 5, 6, 3, 0, 0, 0);
        check("sll.addr", addr_a, 32'h0040_0004);
        check("sll.wdata", wdata_a, 32'h0005_30C0);
        beat(28, 1, 8, 0, 0, 16'h1234, 0, 0);
        check("lui.addr", addr_a, 32'h0040_0008);
        check("lui.wdata", wdata_a, 32'h3C08_1234);
        beat(30, 7, 7, 7, 7, 16'hBEEF, 26'h010_0000, 0);
        check("jal.wdata", wdata_a, 32'h0C10_0000);
        check("jal.count", 32'(count_a), 32'd4);
        check("full.state", 32'(st_b), 32'(ST_FULL));
        check("full.ready", 32'(ready_b), 32'(0));

        beat(31, 1, 2, 3, 0, 0, 0, 0);
        check("illegal.we", 32'(we_a), 32'(0));
        check("illegal.err", 32'(err_a), 32'(1));
        check("illegal.count", 32'(count_a), 32'd4);
        beat(24, 1, 2, 0, 0, 16'hFFFF, 0, 0);
        check("beq.wdata", wdata_a, 32'h1022_FFFF);
        check("full.no_write", 32'(we_b), 32'(0));

        finish = 1'b1; step(); finish = 1'b0;
        check("finish.done", 32'(done_b), 32'(1));
        check("finish.busy", 32'(busy_b), 32'(0));
        step();
        check("done.pulse", 32'(done_a), 32'(0));

        start = 1'b1; step(); start = 1'b0;
        beat(20, 0, 1, 9, 9, 5, 0, 1);
        check("ori.wdata", wdata_a, 32'h3401_0005);
        check("ori.done", 32'(done_a), 32'(1));
        check("ori.busy", 32'(busy_a), 32'(0));

        start = 1'b1; finish = 1'b1; step(); start = 1'b0; finish = 1'b0;
        check("start_wins", 32'(busy_a), 32'(1));

        for (int c = 0; c < 700; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_op = ($urandom_range(0, 15) == 0) ? 5'd31 : 5'($urandom_range(0, 30));
            in_rs = 5'($urandom_range(0, 31));
            in_rt = 5'($urandom_range(0, 31));
            in_rd = 5'($urandom_range(0, 31));
            in_shamt = 5'($urandom_range(0, 31));
            in_imm = 16'($urandom_range(0, 65535));
            in_addr = 26'($urandom());
            start = ($urandom_range(0, 19) == 0);
            finish = ($urandom_range(0, 29) == 0);
            step();
        end
        start = 1'b0; finish = 1'b0; in_valid = 1'b0;

        start = 1'b1; step(); start = 1'b0;
        in_valid = 1'b1; in_op = 5'd1;
        step(); step();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        check("rst.we", 32'(we_a), 32'(0));
        check("rst.count", 32'(count_a), 32'(0));
        check("rst.busy", 32'(busy_a), 32'(0));
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        start = 1'b1; step(); start = 1'b0;
        beat(0, 1, 1, 1, 0, 0, 0, 0);
        check("restart.addr", addr_a, 32'h0040_0000);

        check("sb.drained", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Inverse of the instruction decoder: accepts one symbolic instruction per handshake (op index plus rs/rt/rd/shamt/imm/addr fields) and packs it into a 32-bit MIPS word.
- Streams packed words sequentially into the instruction memory write port.
- Used by the boot/test loader to fill IMEM before the single-cycle core is released from reset.

Parameters:
- DEPTH, 1024, IMEM capacity in words.
- BASE_ADDR, 32'h0040_0000, byte address of the first word written.
- CNT_W, $clog2(DEPTH+1), width of the word counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load session.
- finish  in  1  one-cycle pulse; ends the session.
- in_valid  in  1  instruction fields valid.
- in_ready  out  1  block can accept the fields this cycle.
- in_op  in  5  op index, 0..30 (see Behaviour); 31 is illegal.
- in_rs  in  5  rs field.
- in_rt  in  5  rt field.
- in_rd  in  5  rd field.
- in_shamt  in  5  shift amount.
- in_imm  in  16  immediate / branch offset.
- in_addr  in  26  J-type target.
- imem_we  out  1  write strobe.
- imem_addr  out  32  byte address.
- imem_wdata  out  32  packed instruction word.
- count  out  CNT_W  legal words written in this session.
- busy  out  1  state is LOAD or FULL.
- done  out  1  one-cycle pulse on session end.
- err_illegal  out  1  sticky; an illegal op was received.

Behaviour:
- Reset (async, active-high) clears all state. Outputs after reset:
  - state=IDLE; imem_we, in_ready, busy, done, err_illegal = 0.
  - count=0; imem_addr=BASE_ADDR; imem_wdata=0.
  - A pending write is dropped.
- Op index order, 0..30:
  - R-type: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sra, srl, sll, srav, srlv, sllv, jr.
  - I-type: addi, addiu, andi, ori, xori, lw, sw, beq, bne, slti, sltiu, lui.
  - J-type: j, jal.
- Packing:
  - R-type word = {6'b0, rs, rt, rd, shamt, func}.
  - I-type word = {opr, rs, rt, imm}.
  - J-type word = {opr, addr}.
  - Opcode and func values are those of the MIPS-31 set.
  - The destination of I-type instructions is in_rt.
- Field zeroing (fields an instruction does not use are forced to 0):
  - shamt is nonzero only for sll, srl, sra.
  - rs is forced to 0 for sll, srl, sra and lui.
  - jr keeps rs only.
  - in_rd is ignored for I-type; jal ignores all register fields.
- FSM states IDLE, LOAD, FULL:
  - IDLE, start=1 -> LOAD. count <- 0, err_illegal <- 0. start wins over a simultaneous finish.
  - LOAD: in_ready=1 while count<DEPTH.
  - LOAD, accept (in_valid & in_ready) with a legal op: register the word. The next cycle has imem_we=1, imem_addr = BASE_ADDR + 4*count_old. count increments.
  - LOAD, accept with op 31: the word is dropped, err_illegal <- 1, count unchanged, no write.
  - LOAD, a legal accept makes count==DEPTH -> FULL.
  - FULL: in_ready=0; further in_valid is ignored.
  - LOAD/FULL, finish=1 -> IDLE. A handshake in the same cycle is still accepted; its write occurs on the next cycle together with done=1.
  - start in LOAD/FULL is ignored.
- Latency and throughput: 1 cycle from accept to imem_we; one word per cycle sustained.
- imem_we is high for exactly one cycle per legal accept.
- imem_addr and imem_wdata hold their values when imem_we=0.
- count and err_illegal hold their values in IDLE until the next start.

Decomposition:
- Package mips_isa_pkg holds:
  - opcode and func localparams;
  - the op-index enum (31 entries plus OP_ILLEGAL=31);
  - the state enum.
- Sub-module instr_field_packer: purely combinational. Inputs are op and fields; outputs are word[31:0] and legal.
- The top level holds the FSM, counter, output register and handshake.

Test Plan:
- Reset, then start; send addu op1 rs=2 rt=3 rd=4 shamt=7 -> next cycle imem_we=1, addr=0x00400000, wdata=0x00432021 (shamt zeroed).
- Back-to-back:
  - sll op12 rt=5 rd=6 shamt=3 rs=9 -> wdata=0x000530C0 @0x00400004.
  - lui op28 rs=1 rt=8 imm=0x1234 -> wdata=0x3C081234 @0x00400008.
  - jal op30 addr=0x0100000 -> wdata=0x0C100000.
  - Result: count=4.
- Send op 31 -> no imem_we, err_illegal=1, count unchanged; the next legal beq op24 rs=1 rt=2 imm=0xFFFF writes 0x1022FFFF.
- DEPTH=4 build: five valid beats -> four writes, in_ready=0 after the 4th accept, state FULL; finish -> done pulse, busy=0.
- finish in the same cycle as an accepted ori op20 rs=0 rt=1 imm=5 -> write 0x34010005 and done=1 in the same next cycle.
- Assert rst mid-stream with in_valid high -> imem_we=0 immediately, count=0, busy=0; start afterwards restarts at BASE_ADDR.
